// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encodings and default width for serial_subtractor
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational 1-bit full subtractor x - y - bin
// Ports: x minuend bit, y subtrahend bit, bin borrow in, d difference bit, bout borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when y exceeds x outright, or when they are equal and a borrow ripples in.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, one bit per clock
// Ports: clk; rst_n sync active-low reset; start_valid/start_ready operand handshake with a, b;
//        result_valid/result_ready result handshake with diff, borrow_out, overflow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d      = a;
          b_d      = b;
          // Operand MSBs are kept aside because the shift registers lose them.
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        diff_d   = {fs_d, diff_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // fs_d is the result MSB on the final bit.
          overflow_d = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      cnt_q      <= cnt_d;
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign diff         = diff_q;
  // The borrow flop is only cleared on acceptance, so it retains the last final borrow in IDLE.
  assign borrow_out   = borrow_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking scoreboard bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;
  logic         result_valid;
  logic         result_ready;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .diff         (diff),
    .borrow_out   (borrow_out),
    .overflow     (overflow),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.diff   = x - y;
    e.borrow = (x < y);
    e.ovf    = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for exactly one edge and records the expected result.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start_valid = 1'b1;
    exp_q.push_back(model(x, y));
    step();
    start_valid = 1'b0;
  endtask

  // Counts edges until result_valid; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!result_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!result_valid) lat = -1;
  endtask

  task automatic accept_result();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_valid = 1'b0;
    result_ready = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    rst_n = 1'b1;
    tests_run++;
    if ({diff, borrow_out, overflow, result_valid, start_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got diff=%h bo=%b ov=%b rv=%b sr=%b, want 00 0 0 0 1",
               diff, borrow_out, overflow, result_valid, start_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{8'h05, 8'h03, 8'h80, 8'h7F};
    logic [W-1:0] vb [4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
    exp_t want [4] = '{{8'h02, 1'b0, 1'b0}, {8'hFE, 1'b1, 1'b0},
                       {8'h7F, 1'b0, 1'b1}, {8'h80, 1'b1, 1'b1}};
    exp_t e;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i]);
      // Operands changed right after acceptance must not matter.
      a = ~va[i];
      b = ~vb[i];
      wait_done(lat);
      tests_run++;
      if (lat != W) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, W);
      end
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      tests_run++;
      if ({diff, borrow_out, overflow} !== want[i] || want[i] !== e) begin
        tests_failed++;
        $display("FAIL directed_result[%0d]: got %h/%b/%b, want %h/%b/%b",
                 i, diff, borrow_out, overflow, want[i].diff, want[i].borrow, want[i].ovf);
      end
      accept_result();
      tests_run++;
      if (diff !== want[i].diff || start_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL idle_retain[%0d]: got diff=%h sr=%b, want %h 1", i, diff, start_ready, want[i].diff);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int   lat;
    issue(8'h00, 8'h00);
    wait_done(lat);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if ({diff, borrow_out, overflow, result_valid} !== {e.diff, e.borrow, e.ovf, 1'b1}) begin
        tests_failed++;
        $display("FAIL hold[%0d]: got %h/%b/%b rv=%b, want %h/%b/%b rv=1",
                 c, diff, borrow_out, overflow, result_valid, e.diff, e.borrow, e.ovf);
      end
      step();
    end
    // Offer a new operation on the same edge that takes the result.
    a = 8'h33;
    b = 8'h11;
    start_valid = 1'b1;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    tests_run++;
    if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL accept_edge_no_start: got sr=%b rv=%b, want 1 0", start_ready, result_valid);
    end
    issue(8'h33, 8'h11);
    tests_run++;
    if (start_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL next_edge_start: got sr=%b, want 0", start_ready);
    end
    wait_done(lat);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    tests_run++;
    if (lat != W || {diff, borrow_out, overflow} !== e) begin
      tests_failed++;
      $display("FAIL hold_followup: got lat=%0d %h/%b/%b, want %0d %h/%b/%b",
               lat, diff, borrow_out, overflow, W, e.diff, e.borrow, e.ovf);
    end
    accept_result();
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   lat;
    issue(8'h5A, 8'h3C);
    start_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      a = (c % 2 == 0) ? 8'hFF : 8'h00;
      b = (c % 2 == 0) ? 8'h00 : 8'hFF;
      step();
    end
    wait_done(lat);
    tests_run++;
    if (lat != W - 4) begin
      tests_failed++;
      $display("FAIL ignore_latency: got %0d, want %0d", lat, W - 4);
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    tests_run++;
    if ({diff, borrow_out, overflow} !== e) begin
      tests_failed++;
      $display("FAIL ignore_result: got %h/%b/%b, want %h/%b/%b",
               diff, borrow_out, overflow, e.diff, e.borrow, e.ovf);
    end
    // start_valid still high while in DONE: taking the result must not start a new op.
    accept_result();
    start_valid = 1'b0;
    tests_run++;
    if (start_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ignore_idle: got sr=%b, want 1", start_ready);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   lat;
    logic seen_valid;
    issue(8'h10, 8'h20);
    void'(exp_q.pop_back());
    for (int c = 0; c < 4; c++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests_run++;
    if ({diff, borrow_out, overflow, result_valid, start_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_reset_state: got diff=%h bo=%b ov=%b rv=%b sr=%b, want 00 0 0 0 1",
               diff, borrow_out, overflow, result_valid, start_ready);
    end
    seen_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (result_valid) seen_valid = 1'b1;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_no_valid: got rv pulse=%b, want 0", seen_valid);
    end
    issue(8'h20, 8'h10);
    wait_done(lat);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    tests_run++;
    if (lat != W || {diff, borrow_out, overflow} !== e || e.diff !== 8'h10) begin
      tests_failed++;
      $display("FAIL post_reset_op: got lat=%0d %h/%b/%b, want %0d 10/0/0",
               lat, diff, borrow_out, overflow, W);
    end
    accept_result();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    for (int i = 0; i < 16; i++) begin
      issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      wait_done(lat);
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      tests_run++;
      if (lat != W || {diff, borrow_out, overflow} !== e) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: got lat=%0d %h/%b/%b, want %0d %h/%b/%b",
                 i, lat, diff, borrow_out, overflow, W, e.diff, e.borrow, e.ovf);
      end
      accept_result();
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
